multiplier_32x32: RTL and testbench
===================================

# multiplier_32x32

Iterative 32x32 multiplier implementing the four RV32M multiply operations (MUL, MULH, MULHSU, MULHU) behind a valid/ready handshake on both its input and output sides. It sits beside the integer ALU as a multicycle functional unit. Operands are captured on input handshake. The selected 32-bit result word is returned in a 64-bit extended form on output handshake.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset. Synchronous, active-high: asserted = 1, sampled on `clk`. The port keeps the codebase name despite the polarity.
- `a`  in  32  operand rs1.
- `b`  in  32  operand rs2.
- `op_sel`  in  2  operation: 00 MUL, 01 MULH (s×s), 10 MULHSU (a signed × b unsigned), 11 MULHU (u×u).
- `in_valid_i`  in  1  operands/op valid.
- `out_ready_i`  in  1  consumer ready for result.
- `in_ready_o`  out  1  unit can accept operands.
- `out_valid_o`  out  1  `resultado` valid.
- `resultado`  out  64  result; format defined in Operation.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `in_ready_o` = 1.
  - On `in_valid_i` & `in_ready_o`, latch `a`, `b` and `op_sel`, then go to CALC with the partial-product counter at 0.
- **Sign handling**
  - An operand is signed when `op_sel` selects it as signed: `a` for 01/10, `b` for 01 only.
  - Compute the unsigned magnitude of each operand. A signed 0x80000000 yields magnitude 2^31.
  - `neg` = sign(a) XOR sign(b), each sign counting only when that operand is signed.
- **CALC**, 4 cycles, one per counter value 0..3:
  - Each cycle forms one 16x16 unsigned partial product of the magnitude halves: LL, LH, HL, HH.
  - Add the partial product, shifted by 0/16/16/32, into a 64-bit accumulator.
  - After counter 3, go to DONE and in the same edge register `resultado`:
    - P = `neg` ? −acc : acc (64-bit two's complement).
    - Selected word W = P[31:0] for MUL, P[63:32] otherwise.
    - `resultado` = {32{W[31]}, W} for MUL, MULH and MULHSU; {32'b0, W} for MULHU.
- **DONE**
  - `out_valid_o` = 1 and `resultado` held stable.
  - On `out_ready_i`, go to IDLE.
- `in_ready_o` is 1 only in IDLE, so the unit never accepts new operands while busy. `in_valid_i` held high through CALC is ignored.
- **Reset**, at any state including mid-CALC:
  - Next state IDLE and the counter is cleared.
  - `out_valid_o` = 0, `resultado` = 0, accumulator = 0.
  - `in_ready_o` = 1 after the reset edge.

## Timing
- Accept edge E0, then CALC during E1–E4.
- `resultado` is written and `out_valid_o` rises at E4. The result is visible 4 cycles after accept.
- With `out_ready_i` = 1, DONE lasts 1 cycle and the output handshake completes at E5.
- IDLE and `in_ready_o` = 1 follow from E5. The next accept is possible at E6 (throughput 6 cycles per op).
- With `out_ready_i` = 0, DONE holds indefinitely and both `resultado` and `out_valid_o` stay stable (no drop, no overwrite).
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Package `mult_pkg` holds:
  - the `op_sel` encodings (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU);
  - the FSM state enum;
  - the widths XLEN = 32 and HALF = 16.
- Sub-module `mul16x16u` is a combinational 16x16 → 32 unsigned multiplier, instantiated once and time-multiplexed across the 4 CALC cycles.
- The top level contains the FSM, magnitude/sign logic, accumulator and result formatting.

## Test plan
- MUL: a=10, b=20 → `resultado` = 200; `out_valid_o` exactly 4 cycles after accept.
- MULH: a=1000, b=−500 (0xFFFFFE0C) → 0xFFFFFFFF_FFFFFFFF (−1). MULH: a=b=0x80000000 → 0x00000000_40000000.
- MULHSU: a=1000, b=500 → 0. MULHSU: a=0xFFFFFFFF (−1), b=0xFFFFFFFF → 0xFFFFFFFF_FFFFFFFF. MULHU: a=500, b=400 → 0.
- MULHU: a=b=0xFFFFFFFF → 0x00000000_FFFFFFFE (zero-extended). MUL same operands → 0x00000000_00000001.
- Backpressure: `out_ready_i` = 0 for 10 cycles after `out_valid_o`. Expect `resultado` stable, `in_ready_o` = 0 and new `in_valid_i` ignored. Release → IDLE next cycle.
- Reset asserted during CALC → next cycle IDLE, `out_valid_o` = 0, `resultado` = 0, `in_ready_o` = 1. A fresh MUL 3×7 → 21.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative 32x32 RV32M multiplier.
//   XLEN / HALF : operand width and the half-width used by the 16x16 core
//   op_e        : op_sel encodings (MUL, MULH, MULHSU, MULHU)
//   state_e     : control FSM states
package mult_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned HALF = 16;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/multiplier_32x32_if.sv
// Request/response bundle of the multiplier.
//   a, b, op_sel, in_valid_i   : operand request (master -> slave)
//   in_ready_o                 : unit can accept a request (slave -> master)
//   resultado, out_valid_o     : 64-bit formatted result (slave -> master)
//   out_ready_i                : consumer accepts the result (master -> slave)
interface multiplier_32x32_if
  import mult_pkg::*;
();

  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic [1:0]        op_sel;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [2*XLEN-1:0] resultado;

  modport master (
    output a, b, op_sel, in_valid_i, out_ready_i,
    input  in_ready_o, out_valid_o, resultado
  );

  modport slave (
    input  a, b, op_sel, in_valid_i, out_ready_i,
    output in_ready_o, out_valid_o, resultado
  );

endinterface

// File: rtl/mul16x16u.sv
// Combinational 16x16 -> 32 unsigned multiplier.
//   x, y : unsigned 16-bit factors
//   p    : unsigned 32-bit product
module mul16x16u
  import mult_pkg::*;
(
  input  logic [HALF-1:0]   x,
  input  logic [HALF-1:0]   y,
  output logic [2*HALF-1:0] p
);

  always_comb begin
    p = {{HALF{1'b0}}, x} * {{HALF{1'b0}}, y};
  end

endmodule

// File: rtl/multiplier_32x32.sv
// Iterative 32x32 multiplier for MUL / MULH / MULHSU / MULHU.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active HIGH despite the name
//   bus   : request/response handshake (slave side), see multiplier_32x32_if
// Operands are converted to magnitudes on accept; four cycles of 16x16
// partial products fill a 64-bit accumulator; the sign is reapplied and
// the selected word is extended into resultado on the last CALC edge.
module multiplier_32x32
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multiplier_32x32_if.slave   bus
);

  state_e            state;
  logic [1:0]        cnt;
  op_e               op_q;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              neg;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] res_q;

  // Operand conditioning on the request side (only used on accept).
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;

  always_comb begin
    a_signed = (bus.op_sel == OP_MULH) || (bus.op_sel == OP_MULHSU);
    b_signed = (bus.op_sel == OP_MULH);
    a_neg    = a_signed & bus.a[XLEN-1];
    b_neg    = b_signed & bus.b[XLEN-1];
    // Negating 0x80000000 wraps to itself, which read unsigned is 2^31.
    a_mag_in = a_neg ? (~bus.a + 32'd1) : bus.a;
    b_mag_in = b_neg ? (~bus.b + 32'd1) : bus.b;
  end

  // cnt[1] picks the half of a, cnt[0] the half of b: LL, LH, HL, HH.
  logic [HALF-1:0]   mul_x;
  logic [HALF-1:0]   mul_y;
  logic [2*HALF-1:0] pp;
  logic [2*XLEN-1:0] pp_sh;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   word;
  logic [2*XLEN-1:0] res_next;

  always_comb begin
    mul_x = cnt[1] ? a_mag[XLEN-1:HALF] : a_mag[HALF-1:0];
    mul_y = cnt[0] ? b_mag[XLEN-1:HALF] : b_mag[HALF-1:0];
  end

  mul16x16u u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (pp)
  );

  always_comb begin
    case (cnt)
      2'd0:    pp_sh = {{XLEN{1'b0}}, pp};
      2'd3:    pp_sh = {pp, {XLEN{1'b0}}};
      default: pp_sh = {{HALF{1'b0}}, pp, {HALF{1'b0}}};
    endcase
    acc_next = acc + pp_sh;
    prod     = neg ? (~acc_next + 64'd1) : acc_next;
    word     = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    res_next = (op_q == OP_MULHU) ? {{XLEN{1'b0}}, word}
                                  : {{XLEN{word[XLEN-1]}}, word};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      res_q <= '0;
      op_q  <= OP_MUL;
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            a_mag <= a_mag_in;
            b_mag <= b_mag_in;
            neg   <= a_neg ^ b_neg;
            op_q  <= op_e'(bus.op_sel);
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            res_q <= res_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready_o  = (state == IDLE);
    bus.out_valid_o = (state == DONE);
    bus.resultado   = res_q;
  end

endmodule

// File: tb/tb_multiplier_32x32.sv
module tb_multiplier_32x32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [63:0] sb_q[$];

  multiplier_32x32_if bus ();

  multiplier_32x32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    logic [63:0] ea, eb, p;
    logic [31:0] w;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    w  = (op == 2'b00) ? p[31:0] : p[63:32];
    return (op == 2'b11) ? {32'b0, w} : {{32{w[31]}}, w};
  endfunction

  // Drive one request, push its expected result, wait for out_valid_o.
  // Called and returns at #1 after a rising edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [63:0] exp, output int lat, output int acc_cyc,
                        output bit to);
    int waits;
    to = 1'b0;
    lat = 0;
    acc_cyc = 0;
    bus.a = a;
    bus.b = b;
    bus.op_sel = op;
    bus.in_valid_i = 1'b1;
    waits = 0;
    while (!bus.in_ready_o && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!bus.in_ready_o) begin
      bus.in_valid_i = 1'b0;
      to = 1'b1;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid_i = 1'b0;
    sb_q.push_back(exp);
    while (!bus.out_valid_o && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !bus.out_valid_o;
  endtask

  task automatic test_reset();
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.op_sel = 2'b00;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready_o);
    end
    checks++;
    if (bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid_o);
    end
    checks++;
    if (bus.resultado !== 64'd0) begin
      errors++;
      $display("FAIL reset_resultado: got %h expected 0", bus.resultado);
    end
  endtask

  task automatic test_mul_latency();
    int lat, ac;
    bit to;
    logic [63:0] exp;
    bus.out_ready_i = 1'b1;
    run_op(32'd10, 32'd20, 2'b00, 64'd200, lat, ac, to);
    checks++;
    if (to || lat != 4) begin
      errors++;
      $display("FAIL mul_latency: got %0d (timeout %0b) expected 4", lat, to);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++;
    if (bus.resultado !== exp) begin
      errors++;
      $display("FAIL mul_10x20: got %h expected %h", bus.resultado, exp);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [8] = '{32'd1000, 32'h80000000, 32'd1000, 32'hFFFFFFFF,
                            32'd500, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
    logic [31:0] tb [8] = '{32'hFFFFFE0C, 32'h80000000, 32'd500, 32'hFFFFFFFF,
                            32'd400, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [1:0]  to_ [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
    logic [63:0] te [8] = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000000_40000000,
                            64'h0, 64'hFFFFFFFF_FFFFFFFF, 64'h0,
                            64'h00000000_FFFFFFFE, 64'h00000000_00000001,
                            64'hFFFFFFFF_FFFFFFEB};
    int lat, ac;
    bit to;
    logic [63:0] exp;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], to_[i], te[i], lat, ac, to);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
      checks++;
      if (to || bus.resultado !== exp) begin
        errors++;
        $display("FAIL directed_%0d: got %h (timeout %0b) expected %h", i, bus.resultado, to, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] a, b;
    logic [1:0]  op;
    int lat, ac, prev_ac;
    bit to;
    logic [63:0] exp;
    bus.out_ready_i = 1'b1;
    prev_ac = -1;
    for (int i = 0; i < 12; i++) begin
      a  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      op = 2'($urandom_range(0, 3));
      run_op(a, b, op, model(a, b, op), lat, ac, to);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
      checks++;
      if (to || bus.resultado !== exp) begin
        errors++;
        $display("FAIL b2b_result_%0d: a=%h b=%h op=%0d got %h expected %h",
                 i, a, b, op, bus.resultado, exp);
      end
      if (prev_ac >= 0) begin
        checks++;
        if (ac - prev_ac != 6) begin
          errors++;
          $display("FAIL b2b_throughput_%0d: got %0d cycles expected 6", i, ac - prev_ac);
        end
      end
      prev_ac = ac;
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_return_idle: got ready %b valid %b expected 1 0",
               bus.in_ready_o, bus.out_valid_o);
    end
  endtask

  task automatic test_backpressure();
    int lat, ac;
    bit to;
    logic [63:0] exp, held;
    bus.out_ready_i = 1'b0;
    run_op(32'h12345678, 32'h9ABCDEF0, 2'b10, model(32'h12345678, 32'h9ABCDEF0, 2'b10),
           lat, ac, to);
    held = bus.resultado;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++;
    if (to || held !== exp) begin
      errors++;
      $display("FAIL bp_result: got %h expected %h", held, exp);
    end
    bus.a = 32'd3;
    bus.b = 32'd3;
    bus.op_sel = 2'b00;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.resultado !== exp) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid %b ready %b res %h expected 1 0 %h",
                 i, bus.out_valid_o, bus.in_ready_o, bus.resultado, exp);
      end
    end
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid %b ready %b expected 0 1",
               bus.out_valid_o, bus.in_ready_o);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat, ac;
    bit to;
    logic [63:0] exp;
    bus.out_ready_i = 1'b1;
    bus.a = 32'hDEADBEEF;
    bus.b = 32'h0BADF00D;
    bus.op_sel = 2'b11;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.resultado !== 64'd0) begin
      errors++;
      $display("FAIL midcalc_reset: got valid %b ready %b res %h expected 0 1 0",
               bus.out_valid_o, bus.in_ready_o, bus.resultado);
    end
    run_op(32'd3, 32'd7, 2'b00, 64'd21, lat, ac, to);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    checks++;
    if (to || lat != 4 || bus.resultado !== exp) begin
      errors++;
      $display("FAIL after_reset_mul: got %h lat %0d expected %h lat 4", bus.resultado, lat, exp);
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
